// File: rtl/burst_gate_ctrl_pkg.sv
// Shared types and default widths for the burst gate controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_gate_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } state_t;

endpackage

// File: rtl/burst_gate_ctrl_if.sv
// Sample-path bundle: strobe, I/Q in, gated I/Q out and gate mode.
// Latency: n/a (wires only).
// Backpressure: none; the sample path is free-running.
interface burst_gate_ctrl_if
  import burst_gate_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              smp_en;
  logic [DATA_W-1:0] in_bus_1;
  logic [DATA_W-1:0] in_bus_2;
  logic [DATA_W-1:0] out_bus_1;
  logic [DATA_W-1:0] out_bus_2;
  logic              mode;

  // sample source / sink side
  modport master (
    output smp_en, in_bus_1, in_bus_2,
    input  out_bus_1, out_bus_2, mode
  );

  // gate controller side
  modport slave (
    input  smp_en, in_bus_1, in_bus_2,
    output out_bus_1, out_bus_2, mode
  );

endinterface

// File: rtl/burst_gate_ctrl_dp.sv
// Registered I/Q gate: passes samples while gate_en is high, forces zero otherwise.
// Latency: 1 clk from gate_en/in_* to out_*/mode.
// Backpressure: none; updates every clk regardless of the sample strobe.
module burst_gate_dp
  import burst_gate_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gate_en,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic              mode
);

  // gate both buses and the mode flag in one register stage so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= 1'b0;
      out_1 <= '0;
      out_2 <= '0;
    end else begin
      mode  <= gate_en;
      out_1 <= gate_en ? in_1 : '0;
      out_2 <= gate_en ? in_2 : '0;
    end
  end

endmodule

// File: rtl/burst_gate_ctrl.sv
// TDD burst scheduler: guard/ON/OFF schedule counted on smp_en gates the I/Q path.
// Latency: 1 clk from schedule decision to mode/out_bus_*; burst_done aligned with mode fall.
// Backpressure: none; smp_en low simply holds the schedule. Option macro BURST_GATE_CNT_EN adds a burst limit.
module burst_gate_ctrl
  import burst_gate_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] guard_len,
  input  logic [CNT_W-1:0] on_len,
  input  logic [CNT_W-1:0] off_len,
`ifdef BURST_GATE_CNT_EN
  input  logic [CNT_W-1:0] max_bursts,
  output logic [CNT_W-1:0] burst_cnt,
`endif
  output logic             busy,
  output logic             burst_done,
  burst_gate_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             stop_pend;
  logic             cont_q;
  logic [CNT_W-1:0] on_q, off_q;
  logic             take_start, on_exit, end_run, gate_en, limit;

  // start is honoured only from IDLE, without a same-cycle stop, and with a non-empty burst
  assign take_start = (state == IDLE) && start && !stop && (on_len != '0);

`ifdef BURST_GATE_CNT_EN
  logic [CNT_W-1:0] max_q;
  // the burst now ending is the last one allowed
  assign limit = (max_q != '0) && ((burst_cnt + ONE) == max_q);
`else
  assign limit = 1'b0;
`endif

  // a stop arriving on the final ON strobe also ends the run
  assign end_run = !cont_q || stop_pend || stop || limit;

  // state register, down-counter, pending stop and latched configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      stop_pend <= 1'b0;
      cont_q    <= 1'b0;
      on_q      <= '0;
      off_q     <= '0;
`ifdef BURST_GATE_CNT_EN
      max_q     <= '0;
`endif
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (nxt_state == IDLE)
        stop_pend <= 1'b0;
      else if (state == ON && stop)
        stop_pend <= 1'b1;
      if (take_start) begin
        cont_q <= continuous;
        on_q   <= on_len;
        off_q  <= off_len;
`ifdef BURST_GATE_CNT_EN
        max_q  <= max_bursts;
`endif
      end
    end
  end

  // next state and counter: each timed state lasts its length in smp_en strobes
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    on_exit   = 1'b0;
    case (state)
      IDLE: begin
        if (take_start) begin
          if (guard_len != '0) begin
            nxt_state = GUARD;
            nxt_cnt   = guard_len - ONE;
          end else begin
            nxt_state = ON;
            nxt_cnt   = on_len - ONE;
          end
        end
      end
      GUARD, OFF: begin
        if (stop) begin
          nxt_state = IDLE;
        end else if (bus.smp_en) begin
          if (cnt == '0) begin
            nxt_state = ON;
            nxt_cnt   = on_q - ONE;
          end else begin
            nxt_cnt = cnt - ONE;
          end
        end
      end
      ON: begin
        if (bus.smp_en) begin
          if (cnt == '0) begin
            on_exit = 1'b1;
            if (end_run) begin
              nxt_state = IDLE;
            end else if (off_q != '0) begin
              nxt_state = OFF;
              nxt_cnt   = off_q - ONE;
            end else begin
              nxt_cnt = on_q - ONE;
            end
          end else begin
            nxt_cnt = cnt - ONE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // state-derived outputs: busy from the register, gate enable from the decision
  always_comb begin
    busy    = (state != IDLE);
    gate_en = (nxt_state == ON);
  end

  // burst-end pulse registered so it lines up with the mode fall in the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_done <= 1'b0;
`ifdef BURST_GATE_CNT_EN
      burst_cnt  <= '0;
`endif
    end else begin
      burst_done <= on_exit;
`ifdef BURST_GATE_CNT_EN
      if (take_start)
        burst_cnt <= '0;
      else if (on_exit)
        burst_cnt <= burst_cnt + ONE;
`endif
    end
  end

  burst_gate_dp #(.DATA_W(DATA_W)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .gate_en (gate_en),
    .in_1    (bus.in_bus_1),
    .in_2    (bus.in_bus_2),
    .out_1   (bus.out_bus_1),
    .out_2   (bus.out_bus_2),
    .mode    (bus.mode)
  );

endmodule

// File: doc/burst_gate_ctrl.md
Name: burst_gate_ctrl

Overview:
TDD burst scheduler that sequences the per-channel on/off gate of the modem I/Q datapath.
- Generates the gate `mode` from a programmed guard / ON / OFF sample schedule, counted on the sample strobe.
- Applies the gate to the two 16-bit sample buses through a registered stage, so the gated data and `mode` stay cycle-aligned.
- Sits between the modem control registers and the modulator output stage.

Parameters:
- DATA_W, 16, width of each sample bus.
- CNT_W, 16, width of the guard/ON/OFF length fields and of the internal down-counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- smp_en  input  1  sample strobe; schedule counters advance only when high.
- start  input  1  single-cycle start request.
- stop  input  1  single-cycle stop request.
- continuous  input  1  1 = repeat ON/OFF bursts, 0 = single burst.
- guard_len  input  CNT_W  samples of gate-off before the first burst.
- on_len  input  CNT_W  samples per ON burst.
- off_len  input  CNT_W  samples between bursts (continuous mode).
- in_bus_1  input  DATA_W  I samples.
- in_bus_2  input  DATA_W  Q samples.
- out_bus_1  output  DATA_W  gated I, registered.
- out_bus_2  output  DATA_W  gated Q, registered.
- mode  output  1  gate state, registered, aligned with out_bus_*.
- busy  output  1  high in any state other than IDLE.
- burst_done  output  1  one-cycle pulse at the end of each ON burst.

Behaviour:
- **Reset (async, rst_n=0):** state=IDLE; mode=0, busy=0, burst_done=0, out_bus_1/2=0, counter=0, stop_pending=0, latched config=0.
- **States:** IDLE, GUARD, ON, OFF. busy = (state != IDLE), combinational from the state register.
- **IDLE:**
  - start=1 and stop=0 and on_len!=0 → latch continuous/guard_len/on_len/off_len.
  - Next state is GUARD with cnt=guard_len-1, or ON with cnt=on_len-1 if guard_len==0.
  - start with on_len==0 is ignored. start and stop in the same cycle: stop wins, start is ignored.
- **Counting rule, all timed states:** on smp_en, if cnt==0 the state exits, else cnt decrements. Each state therefore lasts exactly its length in smp_en strobes. Cycles without smp_en hold the state.
- **GUARD exit:** to ON, cnt=on_len-1.
- **ON exit:**
  - burst_done pulses in the same cycle the registered state leaves ON.
  - If latched continuous=1 and stop_pending=0: go to OFF with cnt=off_len-1, or directly to ON (cnt=on_len-1) if off_len==0.
  - Otherwise go to IDLE.
- **OFF exit:** to ON, cnt=on_len-1. There is no guard between bursts.
- **stop while busy:**
  - In GUARD or OFF: next state is IDLE; burst_done does not pulse.
  - In ON: sets stop_pending. The current burst completes in full, then the block goes to IDLE. stop_pending clears on entering IDLE.
- **start while busy:** ignored.
- **Config changes while busy:** ignored; only the values latched at start apply.
- **Datapath (every clk, independent of smp_en):**
  - mode <= (next_state==ON).
  - out_bus_x <= (next_state==ON) ? in_bus_x : 0.
  - Result: data and mode change together, 1 clk after the decision.
- **Arithmetic:** all lengths are unsigned. Length 0 means skip, except on_len, where 0 is rejected at start. The maximum length 2^CNT_W-1 is supported without wrap.

Optional Feature:
- Macro: BURST_GATE_CNT_EN.
- **When defined:**
  - Adds input `max_bursts[CNT_W]`, latched at start; 0 = unlimited.
  - Adds output `burst_cnt[CNT_W]`: cleared on start, incremented with each burst_done, reset value 0.
  - In continuous mode, the block goes to IDLE after the burst where burst_cnt reaches max_bursts, as if stop_pending were set.
- **When undefined:** those ports and logic are absent, and continuous runs until stop.

Decomposition:
- **Shared package `burst_gate_pkg`:**
  - State enum typedef (IDLE=2'd0, GUARD=2'd1, ON=2'd2, OFF=2'd3).
  - Default CNT_W/DATA_W localparams.
- **Sub-module `burst_gate_dp`:**
  - Registered gate for both buses plus the mode register; input is the gate-enable.
  - Keeps the FSM/counter logic separate from the datapath.

Test Plan:
- Single burst: smp_en every cycle, guard=3, on=5, continuous=0, start → mode=0 for 3 smp, mode=1 for exactly 5 cycles with out_bus=in_bus, one burst_done, busy falls, out_bus=0 afterwards.
- Continuous: on=4, off=2, guard=0, smp_en every 2nd clk → mode pattern 1×8clk / 0×4clk repeating; burst_done every 12 clk; stop mid-ON → burst completes, then IDLE.
- stop during OFF → IDLE on the next clk with no burst_done. start+stop in the same cycle in IDLE → stays IDLE. start with on_len=0 → ignored, busy stays 0.
- Zero lengths: guard=0, off=0, on=1, continuous → mode stays 1 continuously with burst_done every smp; ON entered 1 clk after start.
- Reset mid-ON: rst_n low asynchronously → mode, out_bus, busy=0 immediately. After release, block idles until the next start.
- With BURST_GATE_CNT_EN: max_bursts=3, continuous → exactly 3 burst_done pulses, burst_cnt=3, then IDLE.
